// File: rtl/alu_op_sequencer.sv
// Button/switch front end for the 8-bit ALU: loads operands and opcode, captures results,
// and runs a timed demonstration sweep through all eight ALU operations.
//
// state    | meaning
// IDLE     | waiting for a button pulse; operand/opcode loads happen here
// EXEC     | one cycle for the ALU to settle on the new opcode, then capture
// SW_ISSUE | drive the next sweep opcode to the ALU
// SW_HOLD  | capture the sweep result and hold it for HOLD_CYCLES cycles
module alu_op_sequencer #(
    parameter int NB_IN       = 8,
    parameter int NB_OUT      = 8,
    parameter int NB_CODE     = 6,
    parameter int HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NB_IN-1:0]   switch,
    input  logic               b_dato1,
    input  logic               b_dato2,
    input  logic               b_code,
    input  logic               b_sweep,
    output logic [NB_IN-1:0]   alu_a,
    output logic [NB_IN-1:0]   alu_b,
    output logic [NB_CODE-1:0] alu_op,
    input  logic [NB_OUT-1:0]  alu_result,
    output logic [NB_OUT-1:0]  salida,
    output logic               op_valid,
    output logic               op_error,
    output logic               busy
);

    localparam int NB_HOLD = $clog2(HOLD_CYCLES + 1);
    localparam logic [NB_HOLD-1:0] HOLD_LAST = NB_HOLD'(HOLD_CYCLES);

    localparam logic [NB_CODE-1:0] OP_ADD    = NB_CODE'(6'b100000);
    localparam logic [NB_CODE-1:0] OP_SUB    = NB_CODE'(6'b100010);
    localparam logic [NB_CODE-1:0] OP_AND    = NB_CODE'(6'b100100);
    localparam logic [NB_CODE-1:0] OP_OR     = NB_CODE'(6'b100101);
    localparam logic [NB_CODE-1:0] OP_XOR    = NB_CODE'(6'b100110);
    localparam logic [NB_CODE-1:0] OP_SRA    = NB_CODE'(6'b000011);
    localparam logic [NB_CODE-1:0] OP_SRL    = NB_CODE'(6'b000010);
    localparam logic [NB_CODE-1:0] OP_NOR    = NB_CODE'(6'b100111);
    localparam logic [NB_CODE-1:0] OP_FINISH = NB_CODE'(6'b111111);

    typedef enum logic [1:0] {IDLE, EXEC, SW_ISSUE, SW_HOLD} state_t;

    state_t             state;
    logic [3:0]         btn_q;
    logic [3:0]         btn_qq;
    logic [3:0]         btn_pulse;
    logic [2:0]         sw_idx;
    logic [NB_HOLD-1:0] hold_cnt;
    logic [NB_HOLD-1:0] hold_next;
    logic [NB_CODE-1:0] code_in;

    // bit 0 dato1, bit 1 dato2, bit 2 code, bit 3 sweep
    assign btn_pulse = btn_q & ~btn_qq;
    assign hold_next = hold_cnt + 1'b1;
    assign code_in   = switch[NB_CODE-1:0];

    function automatic logic is_legal(input logic [NB_CODE-1:0] code);
        case (code)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    function automatic logic [NB_CODE-1:0] sweep_op(input logic [2:0] idx);
        case (idx)
            3'd0:    return OP_ADD;
            3'd1:    return OP_SUB;
            3'd2:    return OP_AND;
            3'd3:    return OP_OR;
            3'd4:    return OP_XOR;
            3'd5:    return OP_SRA;
            3'd6:    return OP_SRL;
            default: return OP_NOR;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            btn_q    <= '0;
            btn_qq   <= '0;
            sw_idx   <= '0;
            hold_cnt <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_op   <= '0;
            salida   <= '0;
            op_valid <= 1'b0;
            op_error <= 1'b0;
            busy     <= 1'b0;
        end else begin
            btn_q  <= {b_sweep, b_code, b_dato2, b_dato1};
            btn_qq <= btn_q;
            case (state)
                IDLE: begin
                    if (btn_pulse[3]) begin
                        busy     <= 1'b1;
                        op_valid <= 1'b0;
                        op_error <= 1'b0;
                        sw_idx   <= '0;
                        state    <= SW_ISSUE;
                    end else if (btn_pulse[2]) begin
                        if (is_legal(code_in)) begin
                            alu_op   <= code_in;
                            busy     <= 1'b1;
                            op_valid <= 1'b0;
                            op_error <= 1'b0;
                            state    <= EXEC;
                        end else if (code_in == OP_FINISH) begin
                            alu_a    <= '0;
                            alu_b    <= '0;
                            alu_op   <= '0;
                            salida   <= '0;
                            op_valid <= 1'b0;
                            op_error <= 1'b0;
                        end else begin
                            op_error <= 1'b1;
                        end
                    end else if (btn_pulse[0]) begin
                        alu_a    <= switch;
                        op_valid <= 1'b0;
                        op_error <= 1'b0;
                    end else if (btn_pulse[1]) begin
                        alu_b    <= switch;
                        op_valid <= 1'b0;
                        op_error <= 1'b0;
                    end
                end
                EXEC: begin
                    salida   <= alu_result;
                    op_valid <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                SW_ISSUE: begin
                    if (btn_pulse[3]) begin
                        busy     <= 1'b0;
                        op_valid <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        alu_op   <= sweep_op(sw_idx);
                        hold_cnt <= '0;
                        state    <= SW_HOLD;
                    end
                end
                SW_HOLD: begin
                    // an abort wins over a capture on the same edge
                    if (btn_pulse[3]) begin
                        busy     <= 1'b0;
                        op_valid <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        hold_cnt <= hold_next;
                        if (hold_cnt == '0) begin
                            salida   <= alu_result;
                            op_valid <= 1'b1;
                        end
                        if (hold_next == HOLD_LAST) begin
                            if (sw_idx != 3'd7) begin
                                op_valid <= 1'b0;
                                sw_idx   <= sw_idx + 3'd1;
                                state    <= SW_ISSUE;
                            end else begin
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
